dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache controller.
- Sits directly downstream of the CPU MEM stage: the MEM stage addr/data/MemRead/MemWrite feed this block instead of a single-cycle data memory.
- Holds the pipeline via cpu_stall_o during misses and talks to a slow 256-bit-line off-chip memory through a req/ack handshake.

---
 rtl/dcache_ctrl.sv | 155 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate L1 data cache controller.
// It sits after the CPU MEM stage and holds the pipeline while a miss is serviced.
// A miss is serviced through a req/ack handshake with a 256-bit-line backing memory.
module dcache_ctrl #(
  parameter int LINES     = 16,
  parameter int LINE_BITS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [ADDR_W-1:0]    cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int IDX = $clog2(LINES);
  localparam int TAG = ADDR_W - 5 - IDX;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]     valid_q;
  logic [LINES-1:0]     dirty_q;
  logic [TAG-1:0]       tag_arr_q  [LINES];
  logic [LINE_BITS-1:0] data_arr_q [LINES];

  logic [2:0]     word_s;
  logic [IDX-1:0] index_s;
  logic [TAG-1:0] tag_s;
  logic           hit_s;
  logic           wr_hit_s;
  logic           fill_s;
  logic           wb_done_s;
  logic           unused_s;

  // Address split; the byte offset within a word is not used by word accesses.
  assign word_s   = cpu_addr_i[4:2];
  assign index_s  = cpu_addr_i[5+IDX-1:5];
  assign tag_s    = cpu_addr_i[ADDR_W-1:5+IDX];
  assign unused_s = ^cpu_addr_i[1:0];

  // A hit is only recognised in IDLE, so an access completes at most once per miss.
  assign hit_s     = cpu_req_i & valid_q[index_s] & (tag_arr_q[index_s] == tag_s)
                   & (state_q == ST_IDLE);
  assign wr_hit_s  = hit_s & cpu_we_i;
  assign fill_s    = (state_q == ST_ALLOCATE) & mem_ack_i;
  assign wb_done_s = (state_q == ST_WRITEBACK) & mem_ack_i;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Valid/dirty bookkeeping: fills install a clean line, stores mark it dirty.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_s) begin
      valid_q[index_s] <= 1'b1;
      dirty_q[index_s] <= 1'b0;
    end else if (wb_done_s) begin
      // The victim now matches memory, which matters if the requester went away.
      dirty_q[index_s] <= 1'b0;
    end else if (wr_hit_s) begin
      dirty_q[index_s] <= 1'b1;
    end
  end

  // Tag and data arrays: no reset, their contents are qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (fill_s) begin
      tag_arr_q[index_s]  <= tag_s;
      data_arr_q[index_s] <= mem_data_i;
    end else if (wr_hit_s) begin
      data_arr_q[index_s][{word_s, 5'd0} +: 32] <= cpu_data_i;
    end
  end

  // Next-state logic and memory-side outputs.
  always_comb begin
    state_d    = state_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = {ADDR_W{1'b0}};
    mem_data_o = {LINE_BITS{1'b0}};
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i && !hit_s) begin
          if (valid_q[index_s] && dirty_q[index_s]) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_ALLOCATE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = {tag_arr_q[index_s], index_s, 5'b0};
        mem_data_o = data_arr_q[index_s];
        if (mem_ack_i) begin
          // With the requester gone there is nothing to allocate.
          state_d = cpu_req_i ? ST_ALLOCATE : ST_IDLE;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {tag_s, index_s, 5'b0};
        if (mem_ack_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ALLOCATE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // CPU-side outputs: load data only on a read hit, stall on a miss or while busy.
  always_comb begin
    cpu_data_o  = 32'd0;
    cpu_stall_o = (cpu_req_i & ~hit_s) | (state_q != ST_IDLE);
    if (hit_s && !cpu_we_i) begin
      cpu_data_o = data_arr_q[index_s][{word_s, 5'd0} +: 32];
    end else begin
      cpu_data_o = 32'd0;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed testbench for dcache_ctrl (LINES=16, 256-bit lines).
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  int total = 0;
  int bad   = 0;

  logic [255:0] line_a;   // fill for 0x100
  logic [255:0] line_b;   // fill for 0x300
  logic [255:0] line_c;   // fill for 0x440
  logic [255:0] line_d;   // refill of 0x100 after reset
  logic [255:0] exp_line;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'd0;
    cpu_data_i = 32'd0; mem_data_i = 256'd0; mem_ack_i = 1'b0;
    tick(); tick();
    rst_i = 1'b1;
    #1;
    total++;
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || mem_addr_o !== 32'd0 || mem_data_o !== 256'd0) begin
      $display("FAIL reset_mem req=%b we=%b addr=%h expected all zero", mem_req_o, mem_we_o, mem_addr_o);
      bad++;
    end
    total++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'd0) begin
      $display("FAIL reset_cpu stall=%b data=%h expected 0/0", cpu_stall_o, cpu_data_o);
      bad++;
    end
  endtask

  task automatic test_clean_fill();
    int stalls;
    stalls = 0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100;
    #1;
    total++;
    if (cpu_stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
      $display("FAIL miss_idle stall=%b req=%b expected 1/0", cpu_stall_o, mem_req_o);
      bad++;
    end
    stalls += int'(cpu_stall_o);
    tick();
    total++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h100 || cpu_stall_o !== 1'b1) begin
      $display("FAIL alloc_req req=%b we=%b addr=%h stall=%b expected 1/0/00000100/1",
               mem_req_o, mem_we_o, mem_addr_o, cpu_stall_o);
      bad++;
    end
    stalls += int'(cpu_stall_o);
    mem_data_i = line_a; mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0; mem_data_i = 256'd0;
    #1;
    total++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'hDEADBEEF || mem_req_o !== 1'b0) begin
      $display("FAIL fill_hit stall=%b data=%h req=%b expected 0/deadbeef/0", cpu_stall_o, cpu_data_o, mem_req_o);
      bad++;
    end
    total++;
    if (stalls !== 2) begin
      $display("FAIL clean_miss_stalls got=%0d expected=2", stalls);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    cpu_we_i = 1'b1; cpu_addr_i = 32'h104; cpu_data_i = 32'h12345678;
    #1;
    total++;
    if (cpu_stall_o !== 1'b0) begin
      $display("FAIL store_hit stall=%b expected 0", cpu_stall_o);
      bad++;
    end
    tick();
    cpu_we_i = 1'b0; cpu_addr_i = 32'h104;
    #1;
    total++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'h12345678) begin
      $display("FAIL load_after_store stall=%b data=%h expected 0/12345678", cpu_stall_o, cpu_data_o);
      bad++;
    end
    tick();
    cpu_addr_i = 32'h11C;
    #1;
    total++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'hA0000007) begin
      $display("FAIL same_line_hit stall=%b data=%h expected 0/a0000007", cpu_stall_o, cpu_data_o);
      bad++;
    end
    tick();
  endtask

  task automatic test_dirty_miss();
    int stalls;
    stalls = 0;
    exp_line = line_a;
    exp_line[63:32] = 32'h12345678;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300;
    #1;
    stalls += int'(cpu_stall_o);
    tick();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_data_o !== exp_line) begin
        $display("FAIL writeback_c%0d req=%b we=%b addr=%h w1=%h expected 1/1/00000100/12345678",
                 i, mem_req_o, mem_we_o, mem_addr_o, mem_data_o[63:32]);
        bad++;
      end
      stalls += int'(cpu_stall_o);
      mem_ack_i = (i == 2);
      tick();
    end
    mem_ack_i = 1'b0;
    #1;
    total++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h300 || mem_data_o !== 256'd0) begin
      $display("FAIL alloc_after_wb req=%b we=%b addr=%h expected 1/0/00000300 data 0", mem_req_o, mem_we_o, mem_addr_o);
      bad++;
    end
    stalls += int'(cpu_stall_o);
    mem_data_i = line_b; mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    total++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'hB0000000) begin
      $display("FAIL dirty_fill_hit stall=%b data=%h expected 0/b0000000", cpu_stall_o, cpu_data_o);
      bad++;
    end
    total++;
    if (stalls !== 5) begin
      $display("FAIL dirty_miss_stalls got=%0d expected=5", stalls);
      bad++;
    end
    tick();
  endtask

  task automatic test_delayed_fill();
    int held;
    held = 0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h440;
    tick();
    for (int i = 0; i < 10; i++) begin
      if (mem_req_o === 1'b1 && mem_we_o === 1'b0 && mem_addr_o === 32'h440 && cpu_stall_o === 1'b1) held++;
      tick();
    end
    total++;
    if (held !== 10) begin
      $display("FAIL delayed_hold cycles_held=%0d expected=10", held);
      bad++;
    end
    mem_data_i = line_c; mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    #1;
    total++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'hC0000000) begin
      $display("FAIL delayed_fill_hit stall=%b data=%h expected 0/c0000000", cpu_stall_o, cpu_data_o);
      bad++;
    end
    tick();
  endtask

  task automatic test_reset_mid_wb();
    // Dirty the 0x300 line, then force its write-back.
    cpu_we_i = 1'b1; cpu_addr_i = 32'h300; cpu_data_i = 32'hCAFEF00D;
    tick();
    cpu_we_i = 1'b0; cpu_addr_i = 32'h100;
    tick();
    total++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h300 || mem_data_o[31:0] !== 32'hCAFEF00D) begin
      $display("FAIL wb_before_reset req=%b we=%b addr=%h w0=%h expected 1/1/00000300/cafef00d",
               mem_req_o, mem_we_o, mem_addr_o, mem_data_o[31:0]);
      bad++;
    end
    rst_i = 1'b0; cpu_req_i = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    total++;
    if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      $display("FAIL reset_abandon req=%b stall=%b expected 0/0", mem_req_o, cpu_stall_o);
      bad++;
    end
    mem_ack_i = 1'b1; mem_data_i = line_b;
    tick();
    mem_ack_i = 1'b0;
    #1;
    total++;
    if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b0) begin
      $display("FAIL late_ack req=%b stall=%b expected 0/0", mem_req_o, cpu_stall_o);
      bad++;
    end
    cpu_req_i = 1'b1; cpu_addr_i = 32'h100;
    #1;
    total++;
    if (cpu_stall_o !== 1'b1) begin
      $display("FAIL miss_after_reset stall=%b expected 1", cpu_stall_o);
      bad++;
    end
    tick();
    total++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h100) begin
      $display("FAIL refill_req req=%b we=%b addr=%h expected 1/0/00000100", mem_req_o, mem_we_o, mem_addr_o);
      bad++;
    end
    mem_data_i = line_d; mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    cpu_addr_i = 32'h104;
    #1;
    total++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'hD0000001) begin
      $display("FAIL refill_hit stall=%b data=%h expected 0/d0000001", cpu_stall_o, cpu_data_o);
      bad++;
    end
    tick();
  endtask

  task automatic test_stray_ack();
    cpu_req_i = 1'b0;
    mem_data_i = {8{32'h55555555}}; mem_ack_i = 1'b1;
    #1;
    total++;
    if (cpu_stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
      $display("FAIL stray_ack_idle stall=%b req=%b expected 0/0", cpu_stall_o, mem_req_o);
      bad++;
    end
    tick();
    mem_ack_i = 1'b0;
    cpu_req_i = 1'b1; cpu_addr_i = 32'h108;
    #1;
    total++;
    if (cpu_stall_o !== 1'b0 || cpu_data_o !== 32'hD0000002) begin
      $display("FAIL stray_ack_noupdate stall=%b data=%h expected 0/d0000002", cpu_stall_o, cpu_data_o);
      bad++;
    end
    tick();
    cpu_req_i = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      line_a[k*32 +: 32] = 32'hA0000000 + 32'(k);
      line_b[k*32 +: 32] = 32'hB0000000 + 32'(k);
      line_c[k*32 +: 32] = 32'hC0000000 + 32'(k);
      line_d[k*32 +: 32] = 32'hD0000000 + 32'(k);
    end
    line_a[31:0] = 32'hDEADBEEF;
    test_reset();
    test_clean_fill();
    test_back_to_back();
    test_dirty_miss();
    test_delayed_fill();
    test_reset_mid_wb();
    test_stray_ack();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung simulation.
  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
